// File: rtl/exec_stage.sv
// exec_stage: pipelined IITB-RISC execute stage with C/Z flags, valid/ready handshake and flush.
// Define EXEC_MUL_EN to build the multi-cycle shift-add multiplier for opcode 1101.
module exec_stage #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 9,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [1:0]        in_cz,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wr_en,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_br_taken,
    output logic [DATA_W-1:0] out_br_target,
    output logic              c_flag,
    output logic              z_flag
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_JAL = 4'b1001;
    localparam logic [3:0] OP_JLR = 4'b1010;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    function automatic logic signed [DATA_W-1:0] sext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    logic                     accept, busy, start_mul, mul_done, cond_ok;
    logic signed [DATA_W-1:0] sext_p0;
    logic [DATA_W:0]          sum_p0;
    logic [DATA_W-1:0]        res_p0, tgt_p0;
    logic                     wr_p0, mrd_p0, mwr_p0, tkn_p0;
    logic                     upd_c_p0, upd_z_p0, c_p0, z_p0;

    logic                     vld_p1, wr_p1, mrd_p1, mwr_p1, tkn_p1, c_p1, z_p1;
    logic [DATA_W-1:0]        res_p1, store_p1, tgt_p1;
    logic [REG_W-1:0]         rd_p1;

    assign in_ready = !busy && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;

    // Stage p0: decode and evaluate the offered instruction against the current flags
    always_comb begin
        sext_p0  = sext(in_imm);
        cond_ok  = (in_cz == 2'b10) ? c_p1 : (in_cz == 2'b01) ? z_p1 : 1'b1;
        sum_p0   = '0;
        res_p0   = '0;
        tgt_p0   = '0;
        wr_p0    = 1'b0;
        mrd_p0   = 1'b0;
        mwr_p0   = 1'b0;
        tkn_p0   = 1'b0;
        upd_c_p0 = 1'b0;
        upd_z_p0 = 1'b0;
        c_p0     = 1'b0;
        case (in_op)
            OP_ADD: begin
                sum_p0   = {1'b0, in_a} + {1'b0, in_b};
                res_p0   = sum_p0[DATA_W-1:0];
                c_p0     = sum_p0[DATA_W];
                wr_p0    = cond_ok;
                upd_c_p0 = cond_ok;
                upd_z_p0 = cond_ok;
            end
            OP_ADI: begin
                sum_p0   = {1'b0, in_a} + {1'b0, sext_p0};
                res_p0   = sum_p0[DATA_W-1:0];
                c_p0     = sum_p0[DATA_W];
                wr_p0    = 1'b1;
                upd_c_p0 = 1'b1;
                upd_z_p0 = 1'b1;
            end
            OP_NDU: begin
                res_p0   = ~(in_a & in_b);
                wr_p0    = cond_ok;
                upd_z_p0 = cond_ok;
            end
            OP_LHI: begin
                res_p0 = {in_imm, {(DATA_W-IMM_W){1'b0}}};
                wr_p0  = 1'b1;
            end
            OP_LW: begin
                res_p0 = in_a + sext_p0;
                wr_p0  = 1'b1;
                mrd_p0 = 1'b1;
            end
            OP_SW: begin
                res_p0 = in_a + sext_p0;
                mwr_p0 = 1'b1;
            end
            OP_BEQ: begin
                tkn_p0 = (in_a == in_b);
                tgt_p0 = in_pc + sext_p0;
            end
            OP_JAL: begin
                res_p0 = in_pc + ONE;
                wr_p0  = 1'b1;
                tkn_p0 = 1'b1;
                tgt_p0 = in_pc + sext_p0;
            end
            OP_JLR: begin
                res_p0 = in_pc + ONE;
                wr_p0  = 1'b1;
                tkn_p0 = 1'b1;
                tgt_p0 = in_b;
            end
            default: ;
        endcase
        z_p0 = (res_p0 == '0);
    end

`ifdef EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mcand, mplier, acc, mul_b;
    logic [REG_W-1:0]  mul_rd;
    logic [CNT_W-1:0]  cnt;

    assign start_mul = accept && (in_op == OP_MUL);
    assign busy      = (state != S_IDLE);
    assign mul_done  = (state == S_DONE);

    // One partial product per cycle; flush or reset abandons the product
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_mul) begin
                        state  <= S_MUL;
                        mcand  <= in_a;
                        mplier <= in_b;
                        acc    <= '0;
                        cnt    <= '0;
                        mul_b  <= in_b;
                        mul_rd <= in_rd;
                    end
                end
                S_MUL: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign start_mul = 1'b0;
    assign busy      = 1'b0;
    assign mul_done  = 1'b0;
`endif

    // Stage p1: output register and architectural flags
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            res_p1   <= '0;
            store_p1 <= '0;
            rd_p1    <= '0;
            wr_p1    <= 1'b0;
            mrd_p1   <= 1'b0;
            mwr_p1   <= 1'b0;
            tkn_p1   <= 1'b0;
            tgt_p1   <= '0;
            c_p1     <= 1'b0;
            z_p1     <= 1'b0;
        end else begin
            if (accept) begin
                if (upd_c_p0) c_p1 <= c_p0;
                if (upd_z_p0) z_p1 <= z_p0;
            end
`ifdef EXEC_MUL_EN
            if (mul_done && !flush) z_p1 <= (acc == '0);
`endif
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (accept && !start_mul) begin
                vld_p1   <= 1'b1;
                res_p1   <= res_p0;
                store_p1 <= in_b;
                rd_p1    <= in_rd;
                wr_p1    <= wr_p0;
                mrd_p1   <= mrd_p0;
                mwr_p1   <= mwr_p0;
                tkn_p1   <= tkn_p0;
                tgt_p1   <= tgt_p0;
`ifdef EXEC_MUL_EN
            end else if (mul_done) begin
                vld_p1   <= 1'b1;
                res_p1   <= acc;
                store_p1 <= mul_b;
                rd_p1    <= mul_rd;
                wr_p1    <= 1'b1;
                mrd_p1   <= 1'b0;
                mwr_p1   <= 1'b0;
                tkn_p1   <= 1'b0;
                tgt_p1   <= '0;
`endif
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid     = vld_p1;
    assign out_result    = res_p1;
    assign out_store     = store_p1;
    assign out_rd        = rd_p1;
    assign out_wr_en     = wr_p1;
    assign out_mem_rd    = mrd_p1;
    assign out_mem_wr    = mwr_p1;
    assign out_br_taken  = tkn_p1;
    assign out_br_target = tgt_p1;
    assign c_flag        = c_p1;
    assign z_flag        = z_p1;
endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: a driver pushes model results, a monitor pops them on each transfer.
module tb_exec_stage;
    localparam int DW = 16;
    localparam int IW = 9;
    localparam int RW = 3;
`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [3:0]    in_op;
    logic [1:0]    in_cz;
    logic [DW-1:0] in_a, in_b, in_pc;
    logic [IW-1:0] in_imm;
    logic [RW-1:0] in_rd;
    logic [DW-1:0] out_result, out_store, out_br_target;
    logic [RW-1:0] out_rd;
    logic          out_wr_en, out_mem_rd, out_mem_wr, out_br_taken, c_flag, z_flag;

    always #5 clk = ~clk;

    exec_stage #(.DATA_W(DW), .IMM_W(IW), .REG_W(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_cz(in_cz), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_pc(in_pc), .in_rd(in_rd), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_store(out_store),
        .out_rd(out_rd), .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_br_taken(out_br_taken),
        .out_br_target(out_br_target), .c_flag(c_flag), .z_flag(z_flag)
    );

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] result, store, target;
        logic [RW-1:0] rd;
        logic          wr, mrd, mwr, tkn;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic m_c = 1'b0;
    logic m_z = 1'b0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] sx(input logic [IW-1:0] imm);
        int v;
        v = int'(imm);
        if (imm[IW-1]) v = v - (1 << IW);
        return DW'(v);
    endfunction

    function automatic bit is_mul(input logic [3:0] op);
        return MUL_EN && (op == 4'hD);
    endfunction

    function automatic bit has_result(input logic [3:0] op);
        return (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA}) || is_mul(op);
    endfunction

    // Architectural behaviour of one accepted instruction, computed with integer arithmetic
    task automatic model_accept(input logic [3:0] op, input logic [1:0] cz, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [IW-1:0] imm,
                                input logic [DW-1:0] pc, input logic [RW-1:0] rd, input bit drop);
        exp_t        e;
        int unsigned s;
        longint      p;
        bit          ok;
        logic        nc, nz;
        nc = m_c;
        nz = m_z;
        ok = (cz == 2'b10) ? m_c : (cz == 2'b01) ? m_z : 1'b1;
        e.op = op; e.result = '0; e.store = b; e.target = '0; e.rd = rd;
        e.wr = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0; e.tkn = 1'b0;
        case (op)
            4'h0: begin
                s = 32'(a) + 32'(b);
                e.result = DW'(s);
                if (ok) begin e.wr = 1'b1; nc = (s >= (32'd1 << DW)); nz = (e.result == 0); end
            end
            4'h1: begin
                s = 32'(a) + 32'(sx(imm));
                e.result = DW'(s);
                e.wr = 1'b1; nc = (s >= (32'd1 << DW)); nz = (e.result == 0);
            end
            4'h2: begin
                e.result = ~(a & b);
                if (ok) begin e.wr = 1'b1; nz = (e.result == 0); end
            end
            4'h3: begin e.result = DW'(int'(imm) * (1 << (DW - IW))); e.wr = 1'b1; end
            4'h4: begin e.result = DW'(int'(a) + int'(sx(imm))); e.wr = 1'b1; e.mrd = 1'b1; end
            4'h5: begin e.result = DW'(int'(a) + int'(sx(imm))); e.mwr = 1'b1; end
            4'h8: begin e.tkn = (a == b); e.target = DW'(int'(pc) + int'(sx(imm))); end
            4'h9: begin e.result = DW'(int'(pc) + 1); e.wr = 1'b1; e.tkn = 1'b1; e.target = DW'(int'(pc) + int'(sx(imm))); end
            4'hA: begin e.result = DW'(int'(pc) + 1); e.wr = 1'b1; e.tkn = 1'b1; e.target = b; end
            4'hD: begin
                if (MUL_EN) begin
                    p = longint'(a) * longint'(b);
                    e.result = DW'(p);
                    e.wr = 1'b1;
                    if (!drop) nz = (e.result == 0);
                end
            end
            default: ;
        endcase
        m_c = nc;
        m_z = nz;
        if (!drop) sb.push_back(e);
    endtask

    // Offer one instruction starting just after a rising edge; returns just after its accept edge
    task automatic issue(input logic [3:0] op, input logic [1:0] cz, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [IW-1:0] imm, input logic [DW-1:0] pc,
                         input logic [RW-1:0] rd, input bit drop = 1'b0, input bit fl = 1'b0);
        int guard = 0;
        bit got = 1'b0;
        in_valid = 1'b1; in_op = op; in_cz = cz; in_a = a; in_b = b;
        in_imm = imm; in_pc = pc; in_rd = rd; flush = fl;
        forever begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
            guard++;
            if (guard > 100) break;
        end
        if (got) model_accept(op, cz, a, b, imm, pc, rd, drop);
        else begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        if (got && !is_mul(op)) begin
            chk("c_flag", 32'(c_flag), 32'(m_c));
            chk("z_flag", 32'(z_flag), 32'(m_z));
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output", out_result);
            end else begin
                e = sb.pop_front();
                if (has_result(e.op)) chk("out_result", 32'(out_result), 32'(e.result));
                chk("out_store", 32'(out_store), 32'(e.store));
                chk("out_rd", 32'(out_rd), 32'(e.rd));
                chk("out_wr_en", 32'(out_wr_en), 32'(e.wr));
                chk("out_mem_rd", 32'(out_mem_rd), 32'(e.mrd));
                chk("out_mem_wr", 32'(out_mem_wr), 32'(e.mwr));
                chk("out_br_taken", 32'(out_br_taken), 32'(e.tkn));
                if (e.tkn) chk("out_br_target", 32'(out_br_target), 32'(e.target));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        time t0;
        int k;
        bit seen;
        logic [3:0] op;
        logic [DW-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_op = '0; in_cz = '0; in_a = '0; in_b = '0; in_imm = '0; in_pc = '0; in_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        chk("rst_out_br_taken", 32'(out_br_taken), 0);
        chk("rst_c_flag", 32'(c_flag), 0);
        chk("rst_z_flag", 32'(z_flag), 0);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Directed function checks
        issue(4'h0, 2'b00, 16'hFFFF, 16'h0001, 9'h000, 16'h0000, 3'd1);
        issue(4'h0, 2'b00, 16'h0001, 16'h0001, 9'h000, 16'h0000, 3'd2);
        issue(4'h0, 2'b10, 16'h0005, 16'h0006, 9'h000, 16'h0000, 3'd3);
        issue(4'h0, 2'b00, 16'hFFFF, 16'h0002, 9'h000, 16'h0000, 3'd4);
        issue(4'h0, 2'b10, 16'h0005, 16'h0006, 9'h000, 16'h0000, 3'd5);
        issue(4'h0, 2'b01, 16'h0007, 16'h0008, 9'h000, 16'h0000, 3'd6);
        issue(4'h2, 2'b00, 16'hFFFF, 16'hFFFF, 9'h000, 16'h0000, 3'd7);
        issue(4'h2, 2'b01, 16'h00F0, 16'h0F0F, 9'h000, 16'h0000, 3'd1);
        issue(4'h8, 2'b00, 16'h0005, 16'h0005, 9'h1FE, 16'h0010, 3'd0);
        issue(4'h8, 2'b00, 16'h0005, 16'h0006, 9'h1FE, 16'h0010, 3'd0);
        issue(4'hA, 2'b00, 16'h1234, 16'h0040, 9'h000, 16'h0020, 3'd2);
        issue(4'h9, 2'b00, 16'h0000, 16'h0000, 9'h005, 16'h0030, 3'd3);
        issue(4'h3, 2'b00, 16'h0000, 16'h0000, 9'h1AB, 16'h0000, 3'd4);
        issue(4'h4, 2'b00, 16'h0100, 16'hBEEF, 9'h1FF, 16'h0000, 3'd5);
        issue(4'h5, 2'b00, 16'h0100, 16'hCAFE, 9'h003, 16'h0000, 3'd6);
        issue(4'hF, 2'b00, 16'h1111, 16'h2222, 9'h000, 16'h0000, 3'd7);
        drain();

        // Back-pressure: output held while the next instruction waits
        out_ready = 1'b0;
        issue(4'h0, 2'b00, 16'h0003, 16'h0004, 9'h000, 16'h0000, 3'd1);
        fork
            issue(4'h0, 2'b00, 16'h000A, 16'h0014, 9'h000, 16'h0000, 3'd2);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 0);
                    chk("bp_out_valid", 32'(out_valid), 1);
                    chk("bp_out_result", 32'(out_result), 32'h7);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        t0 = $time;
        for (int i = 0; i < 6; i++) issue(4'h1, 2'b00, DW'(i * 3 + 1), DW'(i), 9'(i), 16'h0000, RW'(i));
        chk("throughput_time", 32'($time - t0), 32'd60);
        drain();

        // Flush beats a simultaneous accept, flags still follow the dropped ADI
        issue(4'h1, 2'b00, 16'hFFFF, 16'h0000, 9'h001, 16'h0000, 3'd3, 1'b1, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("flush_out_valid_later", 32'(out_valid), 0);

`ifdef EXEC_MUL_EN
        issue(4'hD, 2'b00, 16'd7, 16'd9, 9'h000, 16'h0000, 3'd4);
        k = 0;
        while (!out_valid && k < 40) begin
            chk("mul_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            k++;
        end
        chk("mul_latency", 32'(k), 32'(DW + 1));
        @(posedge clk); #1;
        chk("mul_z_flag", 32'(z_flag), 32'(m_z));
        drain();
        issue(4'hD, 2'b00, 16'd7, 16'd9, 9'h000, 16'h0000, 3'd5, 1'b1);
        repeat (4) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("mul_flush_in_ready", 32'(in_ready), 1);
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        chk("mul_flush_no_output", 32'(seen), 0);
        chk("mul_flush_z_flag", 32'(z_flag), 32'(m_z));
        issue(4'hD, 2'b00, 16'd3, 16'd5, 9'h000, 16'h0000, 3'd6, 1'b1);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1; m_c = 1'b0; m_z = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        chk("mul_rst_no_output", 32'(seen), 0);
        chk("mul_rst_in_ready", 32'(in_ready), 1);
`endif

        // Randomized traffic with random downstream stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = DW'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = DW'(-int'(ra));
                default: rb = DW'($urandom);
            endcase
            issue(op, 2'($urandom_range(0, 3)), ra, rb, IW'($urandom), DW'($urandom), RW'($urandom));
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset while holding a result with flags set
        out_ready = 1'b0;
        issue(4'h0, 2'b00, 16'hFFFF, 16'h0001, 9'h000, 16'h0000, 3'd1);
        rst = 1'b1;
        sb.delete();
        m_c = 1'b0; m_z = 1'b0;
        @(posedge clk); #1;
        chk("rerst_out_valid", 32'(out_valid), 0);
        chk("rerst_out_wr_en", 32'(out_wr_en), 0);
        chk("rerst_c_flag", 32'(c_flag), 0);
        chk("rerst_z_flag", 32'(z_flag), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rerst_in_ready", 32'(in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised, pipelined execute stage for the IITB-RISC core, sitting between register-read and memory-access. Accepts one decoded instruction per cycle over a valid/ready handshake and evaluates ALU, conditional-execute, address, branch and jump operations. Holds the architectural carry (C) and zero (Z) flags and presents a registered result to the memory stage. Generalises the earlier single-cycle execute logic with width parameters, back-pressure, flush, and an optional multi-cycle multiplier.

## Interface
- DATA_W, 16: datapath width (≥ 16)
- IMM_W, 9: immediate field width, sign-extended unless LHI
- REG_W, 3: destination register index width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept this cycle
- in_op  in  4  opcode
- in_cz  in  2  condition field (00 always, 10 if C, 01 if Z, 11 reserved = always)
- in_a, in_b  in  DATA_W  operands (RA, RB)
- in_imm  in  IMM_W  immediate
- in_pc  in  DATA_W  instruction PC
- in_rd  in  REG_W  destination register
- flush  in  1  discard held and in-flight work
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  DATA_W  ALU result / address / link value
- out_store  out  DATA_W  store data (in_b passthrough)
- out_rd  out  REG_W  destination register
- out_wr_en  out  1  writeback enable
- out_mem_rd, out_mem_wr  out  1  load / store request
- out_br_taken  out  1  redirect fetch
- out_br_target  out  DATA_W  redirect address
- c_flag, z_flag  out  1  architectural flags

## Operation
- Accept when in_valid && in_ready; in_ready = !busy && (!out_valid || out_ready).
- Ops (sext = sign-extend imm to DATA_W):
  - 0000 ADD: a+b; updates C, Z.
  - 0001 ADI: a+sext; updates C, Z.
  - 0010 NDU: ~(a&b); updates Z only.
  - 0011 LHI: imm << (DATA_W−IMM_W); no flags.
  - 0100 LW / 0101 SW: address = a+sext; LW sets out_mem_rd and out_wr_en, SW sets out_mem_wr.
  - 1000 BEQ: taken iff a==b, target pc+sext.
  - 1001 JAL: result pc+1, wr_en, always taken to pc+sext.
  - 1010 JLR: result pc+1, wr_en, taken to b.
  - 1101 MUL: see Configuration.
  - Other opcodes: NOP (out_valid pulses, all enables 0).
- C = carry out of the DATA_W-bit add; Z = (result == 0).
- Conditional ADD/NDU: if the condition fails against current flags, the op is squashed: out_valid=1, wr_en=0, flags unchanged.
- Flags update on the accept edge, so the next accepted instruction sees them with zero-cycle forwarding.
- Output register holds its value while out_valid && !out_ready.
- flush clears out_valid and aborts MUL (busy=0), in the cycle it is sampled; it wins over a simultaneous accept (that instruction is dropped). Flags already updated are not reverted.

## Timing
- Reset: out_valid=0, all out_* = 0, c_flag=z_flag=0, busy=0, in_ready=1 in the following cycle.
- Single-cycle ops: accept at edge N → out_valid at N+1.
- Back-pressure: with out_ready=0 and out_valid=1, in_ready=0; the output is stable until out_ready.
- Simultaneous out_ready and accept: the new result replaces the old at the same edge, giving full throughput.
- rst mid-MUL: aborts with no output.

## Configuration
- EXEC_MUL_EN defined: opcode 1101 MUL computes low DATA_W bits of a*b by shift-add.
  - FSM IDLE→MUL (DATA_W cycles, busy=1, in_ready=0)→DONE (loads output register, returns to IDLE).
  - Result valid DATA_W+1 cycles after accept; updates Z only.
- EXEC_MUL_EN undefined: 1101 behaves as NOP; no FSM or multiplier logic exists.

## Test plan
- Reset then ADD a=0xFFFF, b=0x0001 → next cycle out_result=0x0000, c_flag=1, z_flag=1, out_wr_en=1.
- ADD cz=10 with C=0 → out_valid=1, out_wr_en=0, flags unchanged; repeat after a carry-setting ADD → wr_en=1.
- BEQ a=b=5, pc=0x10, imm=0x1FE (−2) → out_br_taken=1, out_br_target=0x0E; JLR b=0x40 → target 0x40, result pc+1.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_result stable; release → one transfer per cycle resumes, no loss or duplication.
- flush asserted in the same cycle as an accept of ADI → out_valid=0 next cycle, instruction dropped, flags reflect it.
- EXEC_MUL_EN: MUL 7×9 → out_result=63 exactly 17 cycles after accept, in_ready=0 meanwhile; flush at cycle 5 → no output, in_ready=1 next cycle.
